// File: rtl/tank_motion_ctrl.sv
// Frame-scheduled tank motion controller: debounces direction buttons once per frame,
// moves the sprite with wrap-around during blanking, and flags sprite pixels one clock late.
module tank_motion_ctrl #(
    parameter int PIXELS_HORIZ    = 640,
    parameter int PIXELS_VERT     = 480,
    parameter int SPRITE_W        = 60,
    parameter int SPRITE_H        = 60,
    parameter int X_INIT          = 290,
    parameter int Y_INIT          = 210,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int STEP            = 1
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic       Disp_Ena_In,
    input  logic [9:0] Val_Col_In,
    input  logic [9:0] Val_Row_In,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    output logic [9:0] X_Pos_Out,
    output logic [9:0] Y_Pos_Out,
    output logic       Sprite_Hit_Out,
    output logic [5:0] Rom_X_Out,
    output logic [5:0] Rom_Y_Out,
    output logic       Frame_Tick_Out
);

    localparam int          X_MAX   = PIXELS_HORIZ - SPRITE_W;
    localparam int          Y_MAX   = PIXELS_VERT - SPRITE_H;
    localparam logic [3:0]  DB_CNT  = 4'(DEBOUNCE_FRAMES);
    localparam logic [10:0] STEP_11 = 11'(STEP);

    typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE} state_t;

    state_t     state_reg;
    logic [9:0] x_reg, y_reg;
    logic [9:0] x_next, y_next;
    logic       last_px, last_px_reg, last_px_d_reg, frame_tick_reg;
    logic [3:0] btn, active;

    // Button index order: 0 Up, 1 Down, 2 Left, 3 Right
    assign btn = {Right, Left, Down, Up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic [3:0] cnt_reg;
            always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
                if (!Reset_N_In)
                    cnt_reg <= '0;
                else if (state_reg == SAMPLE)
                    cnt_reg <= !btn[gi] ? 4'd0 : (cnt_reg == DB_CNT) ? DB_CNT : cnt_reg + 4'd1;
            end
            assign active[gi] = (cnt_reg == DB_CNT);
        end
    endgenerate

    // Frame tick: rising edge of the registered last-pixel flag, so a pixel that
    // lasts several clocks still yields a single pulse.
    assign last_px = Disp_Ena_In && (Val_Col_In == 10'(PIXELS_HORIZ - 1))
                                 && (Val_Row_In == 10'(PIXELS_VERT - 1));

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            last_px_reg    <= 1'b0;
            last_px_d_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            last_px_reg    <= last_px;
            last_px_d_reg  <= last_px_reg;
            frame_tick_reg <= last_px_reg && !last_px_d_reg;
        end
    end

    logic [10:0] x_sum, y_sum;
    assign x_sum = {1'b0, x_reg} + STEP_11;
    assign y_sum = {1'b0, y_reg} + STEP_11;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (active[2] && !active[3])
            x_next = ({1'b0, x_reg} < STEP_11) ? 10'(X_MAX) : x_reg - 10'(STEP);
        else if (active[3] && !active[2])
            x_next = (x_sum > 11'(X_MAX)) ? 10'd0 : x_sum[9:0];
        if (active[0] && !active[1])
            y_next = ({1'b0, y_reg} < STEP_11) ? 10'(Y_MAX) : y_reg - 10'(STEP);
        else if (active[1] && !active[0])
            y_next = (y_sum > 11'(Y_MAX)) ? 10'd0 : y_sum[9:0];
    end

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_reg <= IDLE;
            x_reg     <= 10'(X_INIT);
            y_reg     <= 10'(Y_INIT);
        end else begin
            case (state_reg)
                IDLE:    if (frame_tick_reg) state_reg <= SAMPLE;
                SAMPLE:  state_reg <= UPDATE;
                UPDATE: begin
                    x_reg     <= x_next;
                    y_reg     <= y_next;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic hit;
    assign hit = Disp_Ena_In
              && ({1'b0, Val_Col_In} >= {1'b0, x_reg})
              && ({1'b0, Val_Col_In} <= {1'b0, x_reg} + 11'(SPRITE_W - 1))
              && ({1'b0, Val_Row_In} >= {1'b0, y_reg})
              && ({1'b0, Val_Row_In} <= {1'b0, y_reg} + 11'(SPRITE_H - 1));

    // Only the low 6 bits of the local offset are needed; they equal the low bits of the full difference.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            Sprite_Hit_Out <= 1'b0;
            Rom_X_Out      <= '0;
            Rom_Y_Out      <= '0;
        end else begin
            Sprite_Hit_Out <= hit;
            Rom_X_Out      <= hit ? (Val_Col_In[5:0] - x_reg[5:0]) : 6'd0;
            Rom_Y_Out      <= hit ? (Val_Row_In[5:0] - y_reg[5:0]) : 6'd0;
        end
    end

    assign X_Pos_Out      = x_reg;
    assign Y_Pos_Out      = y_reg;
    assign Frame_Tick_Out = frame_tick_reg;

endmodule
